// File: rtl/camera_ctrl_fsm.sv
// camera_ctrl_fsm
// Sequencing controller for the 2x2 pixel-array camera: holds a programmable
// exposure time (adjusted by exp_inc/exp_dec while idle) and drives the pixel
// strobes through erase -> expose -> two-row readout.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high
//   init     start a frame (level, sampled only in IDLE)
//   exp_inc  raise exposure by 1 per cycle while high (IDLE only)
//   exp_dec  lower exposure by 1 per cycle while high (IDLE only)
//   erase    pixel reset              (reset value 1)
//   expose   pixel integrate          (reset value 0)
//   nre_1    row 1 read enable, low   (reset value 1)
//   nre_2    row 2 read enable, low   (reset value 1)
//   adc      ADC sample strobe        (reset value 0)
//   ovf      saturation pulse, only when CAMERA_OVF_EN is defined
//
// Optional feature macro: CAMERA_OVF_EN
//
// state  | meaning
// IDLE   | erase asserted, waiting for init, exposure adjustable
// EXPOSE | integrating, counter runs down exp_time cycles
// R1     | row 1 enabled
// R2     | row 1 enabled, ADC sample
// R3     | row-switch gap
// R4     | row 2 enabled
// R5     | row 2 enabled, ADC sample

module camera_ctrl_fsm #(
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 15,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic exp_inc,
    input  logic exp_dec,
    output logic erase,
    output logic expose,
    output logic nre_1,
    output logic nre_2,
    output logic adc
`ifdef CAMERA_OVF_EN
    ,
    output logic ovf
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXPOSE = 3'd1,
        R1     = 3'd2,
        R2     = 3'd3,
        R3     = 3'd4,
        R4     = 3'd5,
        R5     = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] exp_time, exp_time_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             erase_d, expose_d, nre_1_d, nre_2_d, adc_d;
`ifdef CAMERA_OVF_EN
    logic             ovf_d;
`endif

    // Strobes are decoded from the current state and then registered, so they
    // trail the state register by one cycle (expose rises one edge after init
    // is sampled).
    always_comb begin
        state_nxt    = state;
        exp_time_nxt = exp_time;
        cnt_nxt      = cnt;
        erase_d      = 1'b0;
        expose_d     = 1'b0;
        nre_1_d      = 1'b1;
        nre_2_d      = 1'b1;
        adc_d        = 1'b0;
`ifdef CAMERA_OVF_EN
        ovf_d        = 1'b0;
`endif
        case (state)
            IDLE: begin
                erase_d = 1'b1;
                if (init) begin
                    state_nxt = EXPOSE;
                    cnt_nxt   = exp_time;
                end else if (exp_inc && !exp_dec) begin
                    if (exp_time >= CNT_W'(EXP_MAX)) begin
`ifdef CAMERA_OVF_EN
                        ovf_d = 1'b1;
`endif
                    end else begin
                        exp_time_nxt = exp_time + CNT_W'(1);
                    end
                end else if (exp_dec && !exp_inc) begin
                    if (exp_time <= CNT_W'(EXP_MIN)) begin
`ifdef CAMERA_OVF_EN
                        ovf_d = 1'b1;
`endif
                    end else begin
                        exp_time_nxt = exp_time - CNT_W'(1);
                    end
                end
            end
            EXPOSE: begin
                expose_d = 1'b1;
                // Loaded with exp_time on entry; leaving when it reads 1 gives
                // exactly exp_time cycles in this state.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = R1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            R1: begin
                nre_1_d   = 1'b0;
                state_nxt = R2;
            end
            R2: begin
                nre_1_d   = 1'b0;
                adc_d     = 1'b1;
                state_nxt = R3;
            end
            R3: begin
                state_nxt = R4;
            end
            R4: begin
                nre_2_d   = 1'b0;
                state_nxt = R5;
            end
            R5: begin
                nre_2_d   = 1'b0;
                adc_d     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            exp_time <= CNT_W'(EXP_DEFAULT);
            cnt      <= '0;
            erase    <= 1'b1;
            expose   <= 1'b0;
            nre_1    <= 1'b1;
            nre_2    <= 1'b1;
            adc      <= 1'b0;
`ifdef CAMERA_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            exp_time <= exp_time_nxt;
            cnt      <= cnt_nxt;
            erase    <= erase_d;
            expose   <= expose_d;
            nre_1    <= nre_1_d;
            nre_2    <= nre_2_d;
            adc      <= adc_d;
`ifdef CAMERA_OVF_EN
            ovf      <= ovf_d;
`endif
        end
    end

endmodule
